// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, fill FSM states and shared address helpers.
package fb_pkg;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int ADDR_W    = 17;
    localparam int PIX_W     = 12;
    typedef enum logic [2:0] {IDLE, CLIP, WAIT_VB, FILL, DONE} fill_state_t;
    // y*320 as (y<<8)+(y<<6) so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] y);
        return (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6);
    endfunction
endpackage

// File: rtl/fb_fill_engine_if.sv
// fb_fill_engine_if: fill command, end-of-frame pulse and framebuffer port A bundle.
interface fb_fill_engine_if import fb_pkg::*; ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [8:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [8:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [PIX_W-1:0]  cmd_color;
    logic              cmd_vsync;
    logic              v_blank_interupt;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_data;
    logic              fb_we;
    logic              busy;
    logic              done;
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_vsync, v_blank_interupt,
        input  cmd_ready, fb_addr, fb_data, fb_we, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_vsync, v_blank_interupt,
        output cmd_ready, fb_addr, fb_data, fb_we, busy, done
    );
endinterface

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: row-major pixel address walker over a clipped rectangle.
module fb_addr_gen #(
    parameter int ADDR_W   = fb_pkg::ADDR_W,
    parameter int FB_WIDTH = fb_pkg::FB_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [8:0]        w_eff,
    input  logic [7:0]        h_eff,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel
);
    logic [8:0]        col, w_q;
    logic [7:0]        row, h_q;
    logic [ADDR_W-1:0] row_base;
    logic              end_row;

    assign end_row    = col == w_q - 9'd1;
    assign last_pixel = end_row && row == h_q - 8'd1;

    // the final pixel holds the address so it never steps past the rectangle
    always_ff @(posedge clock) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (load) begin
            col      <= '0;
            row      <= '0;
            w_q      <= w_eff;
            h_q      <= h_eff;
            row_base <= start_addr;
            addr     <= start_addr;
        end else if (step && !last_pixel) begin
            col      <= end_row ? '0 : col + 9'd1;
            row      <= end_row ? row + 8'd1 : row;
            row_base <= end_row ? row_base + ADDR_W'(FB_WIDTH) : row_base;
            addr     <= end_row ? row_base + ADDR_W'(FB_WIDTH) : addr + ADDR_W'(1);
        end
    end
endmodule

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: clipped rectangle fill into framebuffer port A, one pixel per clock,
// optionally held until the display's end-of-frame pulse.
module fb_fill_engine import fb_pkg::*; #(
    parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
    parameter int ADDR_W    = fb_pkg::ADDR_W,
    parameter int PIX_W     = fb_pkg::PIX_W
) (
    input  logic           clock,
    input  logic           reset,
    fb_fill_engine_if.slave bus
);
    fill_state_t       state, next_state;
    logic [8:0]        x_q, w_q, w_eff;
    logic [7:0]        y_q, h_q, h_eff;
    logic [PIX_W-1:0]  color_q, data_d, data_q;
    logic              vsync_q, accept, empty, last_pixel;
    logic              we_d, done_d, busy_d, ready_d;
    logic              we_q, done_q, busy_q, ready_q;
    logic [ADDR_W-1:0] w_room, h_room, start_addr;

    assign accept = bus.cmd_valid && ready_q;

    always_ff @(posedge clock) begin
        if (accept) begin
            x_q     <= bus.cmd_x;
            y_q     <= bus.cmd_y;
            w_q     <= bus.cmd_w;
            h_q     <= bus.cmd_h;
            color_q <= bus.cmd_color;
            vsync_q <= bus.cmd_vsync;
        end
    end

    // room values underflow when the origin is off-screen, but empty covers that case
    always_comb begin
        w_room     = ADDR_W'(FB_WIDTH) - ADDR_W'(x_q);
        h_room     = ADDR_W'(FB_HEIGHT) - ADDR_W'(y_q);
        empty      = ADDR_W'(x_q) >= ADDR_W'(FB_WIDTH) || ADDR_W'(y_q) >= ADDR_W'(FB_HEIGHT)
                     || w_q == '0 || h_q == '0;
        w_eff      = ADDR_W'(w_q) > w_room ? w_room[8:0] : w_q;
        h_eff      = ADDR_W'(h_q) > h_room ? h_room[7:0] : h_q;
        start_addr = row_base(y_q) + ADDR_W'(x_q);
    end

    fb_addr_gen #(.ADDR_W(ADDR_W), .FB_WIDTH(FB_WIDTH)) u_addr_gen (
        .clock      (clock),
        .reset      (reset),
        .load       (state == CLIP),
        .step       (state == FILL),
        .start_addr (start_addr),
        .w_eff      (w_eff),
        .h_eff      (h_eff),
        .addr       (bus.fb_addr),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= next_state;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CLIP;
            CLIP:    next_state = empty ? DONE : vsync_q ? WAIT_VB : FILL;
            WAIT_VB: if (!bus.v_blank_interupt) next_state = FILL;
            FILL:    if (last_pixel) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // outputs are registered, so they are decoded from the state being entered
    always_comb begin
        we_d    = next_state == FILL;
        done_d  = next_state == DONE;
        busy_d  = next_state != IDLE;
        ready_d = next_state == IDLE;
        data_d  = we_d ? color_q : '0;
    end

    assign bus.fb_we     = we_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.cmd_ready = ready_q;
    assign bus.fb_data   = data_q;
endmodule

// File: tb/tb_fb_fill_engine.sv
// tb_fb_fill_engine: directed fill commands with hand-computed addresses and timing.
module tb_fb_fill_engine;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   wr_cnt, done_cnt, data_err, max_addr, first_we, last_we, done_cyc, t_acc;
    int   addr_q[$];
    logic [11:0] exp_color;

    fb_fill_engine_if bus ();
    fb_fill_engine dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.fb_we) begin
            wr_cnt++;
            addr_q.push_back(int'(bus.fb_addr));
            if (int'(bus.fb_addr) > max_addr) max_addr = int'(bus.fb_addr);
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            if (bus.fb_data !== exp_color) data_err++;
        end else if (!bus.busy && !reset && bus.fb_data !== 12'h000) data_err++;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic issue(input int x, input int y, input int w, input int h,
                         input logic [11:0] color, input logic vs);
        @(negedge clock);
        wr_cnt = 0; done_cnt = 0; data_err = 0; max_addr = 0;
        first_we = -1; last_we = -1; done_cyc = -1;
        addr_q.delete();
        exp_color     = color;
        bus.cmd_x     = 9'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_w     = 9'(w);
        bus.cmd_h     = 8'(h);
        bus.cmd_color = color;
        bus.cmd_vsync = vs;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clock);
        check("ready_before_issue", int'(bus.cmd_ready), 1);
        @(posedge clock);
        #1;
        t_acc = cyc - 1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && done_cnt == 0; i++) @(posedge clock);
        @(negedge clock);
        check("done_seen", done_cnt, 1);
    endtask

    task automatic check_addrs(input string tag, input int exp[4]);
        check({tag, "_count"}, addr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check({tag, "_addr"}, i < addr_q.size() ? addr_q[i] : -1, exp[i]);
    endtask

    initial begin
        int ex[4] = '{320, 0, 0, 0};
        int ey[4] = '{0, 240, 0, 0};
        int ew[4] = '{4, 4, 0, 4};
        int eh[4] = '{4, 4, 4, 0};
        bus.cmd_valid = 1'b0;
        bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
        bus.cmd_color = '0; bus.cmd_vsync = 1'b0;
        bus.v_blank_interupt = 1'b1;
        exp_color = '0;
        wr_cnt = 0; done_cnt = 0; data_err = 0; max_addr = 0;
        first_we = -1; last_we = -1; done_cyc = -1; t_acc = 0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", int'(bus.cmd_ready), 0);
        check("rst_we", int'(bus.fb_we), 0);
        check("rst_addr", int'(bus.fb_addr), 0);
        check("rst_data", int'(bus.fb_data), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", int'(bus.cmd_ready), 1);

        issue(0, 0, 2, 2, 12'hF00, 1'b0);
        wait_done();
        check("basic_first_we", first_we - t_acc, 2);
        check("basic_done_at", done_cyc - t_acc, 6);
        check("basic_contig", last_we - first_we + 1, wr_cnt);
        check("basic_data", data_err, 0);
        check_addrs("basic", '{0, 1, 320, 321});

        issue(318, 238, 10, 10, 12'h0F0, 1'b0);
        wait_done();
        check_addrs("clip", '{76478, 76479, 76798, 76799});
        check("clip_max_addr", max_addr, 76799);
        check("clip_done_at", done_cyc - t_acc, 6);
        check("clip_data", data_err, 0);

        for (int k = 0; k < 4; k++) begin
            issue(ex[k], ey[k], ew[k], eh[k], 12'h00F, 1'b0);
            wait_done();
            check("empty_writes", wr_cnt, 0);
            check("empty_done_at", done_cyc - t_acc, 2);
        end

        issue(5, 5, 1, 1, 12'h5A5, 1'b1);
        bus.v_blank_interupt = 1'b0;
        @(posedge clock);
        #1;
        bus.v_blank_interupt = 1'b1;
        repeat (98) @(posedge clock);
        #1;
        check("vs_busy_wait", int'(bus.busy), 1);
        check("vs_no_early_write", wr_cnt, 0);
        bus.v_blank_interupt = 1'b0;
        @(posedge clock);
        #1;
        bus.v_blank_interupt = 1'b1;
        wait_done();
        check("vs_writes", wr_cnt, 1);
        check("vs_addr", addr_q.size() > 0 ? addr_q[0] : -1, 1605);
        check("vs_first_we", first_we - t_acc, 101);
        check("vs_done_at", done_cyc - t_acc, 102);
        check("vs_data", data_err, 0);

        issue(0, 0, 16, 16, 12'hABC, 1'b0);
        repeat (20) @(posedge clock);
        @(negedge clock);
        bus.cmd_x = 9'd100; bus.cmd_y = 8'd100; bus.cmd_w = 9'd3; bus.cmd_h = 8'd3;
        bus.cmd_valid = 1'b1;
        check("busy_ready_low", int'(bus.cmd_ready), 0);
        repeat (10) @(negedge clock);
        bus.cmd_valid = 1'b0;
        wait_done();
        repeat (20) @(negedge clock);
        check("busy_writes", wr_cnt, 256);
        check("busy_done_cnt", done_cnt, 1);
        check("busy_last_addr", addr_q.size() > 0 ? addr_q[addr_q.size()-1] : -1, 4815);
        check("busy_max_addr", max_addr, 4815);
        check("busy_data", data_err, 0);

        issue(0, 0, 4, 4, 12'h123, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_we", int'(bus.fb_we), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_writes", wr_cnt, 5);
        @(negedge clock);
        check("midrst_ready", int'(bus.cmd_ready), 1);
        repeat (10) @(negedge clock);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_writes_after", wr_cnt, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_fill_engine.md
# fb_fill_engine

Hardware rectangle-fill engine on the write side of the 320x240x12-bit framebuffer. It accepts a fill command from the CPU bus (origin, size, colour) and clips it to the screen. It then writes the rectangle into framebuffer port A at one pixel per clock, while the display controller reads port B. An optional vsync-gated mode starts the fill on the display's end-of-frame pulse to avoid tearing.

## Interface
Parameters:
- FB_WIDTH, 320, pixels per framebuffer row
- FB_HEIGHT, 240, rows per frame
- ADDR_W, 17, framebuffer address width
- PIX_W, 12, pixel width (RGB 4:4:4)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x  in  9  left column
- cmd_y  in  8  top row
- cmd_w  in  9  width in pixels
- cmd_h  in  8  height in rows
- cmd_color  in  PIX_W  fill colour
- cmd_vsync  in  1  1 = wait for end-of-frame before writing
- v_blank_interupt  in  1  active-low one-cycle end-of-frame pulse from the display controller
- fb_addr  out  ADDR_W  port A address, = row*FB_WIDTH + col
- fb_data  out  PIX_W  port A write data
- fb_we  out  1  port A write enable
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLIP, WAIT_VB, FILL, DONE.
- IDLE: cmd_ready=1. A command is accepted on a cycle with cmd_valid && cmd_ready. All cmd_* fields are latched on that cycle, and the state moves to CLIP.
- CLIP (1 cycle):
  - If x >= FB_WIDTH, y >= FB_HEIGHT, w == 0 or h == 0, the command is empty: go to DONE with no writes.
  - Otherwise compute w_eff = min(w, FB_WIDTH-x) and h_eff = min(h, FB_HEIGHT-y).
  - Compute start address y*FB_WIDTH + x, using shift-add (y<<8)+(y<<6)+x. No multiplier.
  - Next state is WAIT_VB if cmd_vsync is set, else FILL.
- WAIT_VB: stay until v_blank_interupt == 0, then go to FILL on the next edge.
- FILL: one write per cycle, row-major, left to right.
  - The column counter runs 0..w_eff-1.
  - At the end of a row: row_base += FB_WIDTH, and the address reloads to the new row_base.
  - After the last pixel of row h_eff-1, go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in every state except IDLE.
- fb_data = latched colour whenever fb_we=1. It is don't-care otherwise, but held at 0 in IDLE.
- Addresses never exceed FB_WIDTH*FB_HEIGHT-1 (76799). All arithmetic is ADDR_W-bit unsigned with no wrap.

## Timing
- Reset values: cmd_ready=0 during reset, 1 the first cycle after. fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0. State is IDLE.
- Outputs are registered.
- Latency without vsync: acceptance at cycle T; CLIP at T+1; first fb_we=1 at T+2.
- Last write is at T+1+w_eff*h_eff. done is asserted the cycle after the last write.
- Empty command: done at T+2, with no fb_we.
- With vsync: the first write is on the cycle after the sampled v_blank_interupt low. A pulse that coincides with the CLIP cycle is not seen, so the engine waits for the next frame.
- fb_we is continuous across row boundaries; there are no bubbles.
- cmd_valid while busy is ignored (cmd_ready=0). The command is not queued.
- Reset mid-fill: on the next edge fb_we=0 and the state is IDLE. The partial rectangle stays written. No done pulse.

## Structure
- Shared package fb_pkg:
  - FB_WIDTH, FB_HEIGHT, ADDR_W, PIX_W
  - the state enum
  - the row-base shift-add helper, also usable by future blit/copy engines
- One natural sub-module, fb_addr_gen:
  - holds the col/row counters, row_base and the address register
  - inputs load, step, start_addr, w_eff, h_eff
  - outputs addr, last_pixel
- The FSM and command latch live in fb_fill_engine.

## Test plan
- Reset, then fill x=0,y=0,w=2,h=2,color=12'hF00, cmd_vsync=0 -> fb_we high for 4 cycles starting T+2, addresses 0,1,320,321, done at T+6.
- Fill x=318,y=238,w=10,h=10,color=12'h0F0 -> clipped to 2x2, addresses 76478,76479,76798,76799, no address above 76799.
- Empty commands: x=320 / y=240 / w=0 / h=0 -> zero fb_we cycles, done at T+2.
- cmd_vsync=1, fill 1x1 at (5,5), v_blank_interupt low 100 cycles after acceptance -> single write to addr 1605 on the cycle after the pulse, busy high throughout the wait.
- Second cmd_valid during a 16x16 fill -> cmd_ready=0, command ignored, exactly 256 writes, one done pulse.
- reset asserted mid-fill of 4x4 at (0,0) after 5 writes -> fb_we=0 next cycle, no done pulse, cmd_ready=1 after reset deasserts.
